cam_capture_ctrl: RTL and testbench
===================================

CAM_CAPTURE_CTRL -- requirements
Module: cam_capture_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, 176, active pixels per line written to memory.
REQ-002 SHALL provide parameter HEIGHT, 144, active lines per frame written to memory.
REQ-003 SHALL provide parameter ADDR_W, 15, write-address width; WIDTH*HEIGHT <= 2**ADDR_W.
REQ-004 SHALL provide parameter THR_W, 4'd3, per-channel white threshold (classify mode).
REQ-005 SHALL provide parameter THR_R, 4'd3, red threshold (classify mode).
REQ-006 SHALL provide parameter THR_B, 4'd2, blue threshold (classify mode).
REQ-007 SHALL provide port CLK  in  1  single system clock; every flop is on its rising edge.
REQ-008 SHALL provide port RESET  in  1  synchronous, active-high reset.
REQ-009 SHALL provide port CAM_PCLK  in  1  camera pixel clock, sampled as data.
REQ-010 SHALL provide port CAM_VSYNC  in  1  camera frame sync; rising edge starts a frame.
REQ-011 SHALL provide port CAM_HREF  in  1  camera line-valid, high during active bytes.
REQ-012 SHALL provide port CAM_DATA  in  8  camera byte bus.
REQ-013 SHALL provide port MODE  in  2  0=RGB565, 1=RGB444, 2=classify, 3=raw byte.
REQ-014 SHALL provide port ENABLE  in  1  capture enable, sampled at frame start.
REQ-015 SHALL provide port W_ADDR  out  ADDR_W  memory write address.
REQ-016 SHALL provide port W_DATA  out  8  RGB332 pixel.
REQ-017 SHALL provide port W_EN  out  1  one-CLK write strobe.
REQ-018 SHALL provide port FRAME_DONE  out  1  one-CLK pulse at end of a captured frame.
REQ-019 SHALL provide port FRAME_CNT  out  8  captured-frame counter, wraps 255->0.
REQ-020 SHALL provide port OVERFLOW  out  1  sticky: pixel or line beyond WIDTH/HEIGHT seen.

Function
REQ-021 SHALL pass CAM_PCLK, CAM_VSYNC, CAM_HREF and CAM_DATA through a 2-flop synchronizer; CLK SHALL be >= 4x PCLK.
REQ-022 SHALL act only on a synchronized PCLK rising edge (pclk_s & ~pclk_d), with VSYNC/HREF edges evaluated on that same sample.
REQ-023 SHALL implement states IDLE (wait VSYNC rise), FRAME (HREF low), LINE (HREF high).
REQ-024 VSYNC rise in any state: x=0, y=0, byte phase=0, next state FRAME if ENABLE=1 else IDLE.
REQ-025 When VSYNC rise and HREF fall coincide on one sample, VSYNC SHALL take priority.
REQ-026 FRAME->LINE on HREF high; LINE->FRAME on HREF fall, with y+1 (saturating at HEIGHT), x=0, phase=0.
REQ-027 In LINE, phase 0 stores CAM_DATA as pixel bits [7:0]; phase 1 stores bits [15:8] and forms the pixel.
REQ-028 On phase-1 completion, if x<WIDTH and y<HEIGHT: W_EN=1 for exactly one CLK, registered one CLK after the detect cycle, with W_ADDR=y*WIDTH+x; then x+1.
REQ-029 If x>=WIDTH or y>=HEIGHT, SHALL drop the pixel, hold W_EN=0 and set OVERFLOW.
REQ-030 MODE 0: W_DATA={p[15:13],p[10:8],p[4:3]}.
REQ-031 MODE 1: W_DATA={p[11:9],p[7:5],p[3:2]}.
REQ-032 MODE 2 priority: R,G,B (p[11:8],p[7:4],p[3:0]) all >=THR_W -> 8'hFF; else R>THR_R -> 8'hE0; else B>=THR_B -> 8'h03; else 8'h00.
REQ-033 MODE 3: W_DATA=p[7:0].
REQ-034 MODE SHALL be latched at VSYNC rise; changes mid-frame SHALL have no effect until the next frame.
REQ-035 VSYNC rise leaving FRAME/LINE with >=1 pixel written this frame: FRAME_DONE pulses one CLK and FRAME_CNT+1.
REQ-036 ENABLE low at frame start: the whole frame SHALL be ignored, with no W_EN and no FRAME_DONE.

Reset
REQ-037 RESET SHALL set state=IDLE, x=y=0, phase=0, W_EN=0, W_ADDR=0, W_DATA=0, FRAME_DONE=0, FRAME_CNT=0, OVERFLOW=0, and clear synchronizer/edge flops.
REQ-038 RESET mid-frame: no write SHALL occur until the next VSYNC rise.

Structure
REQ-039 Package cam_pkg SHALL hold the MODE encodings, RGB332 constants RED=8'hE0, GREEN=8'h1C, BLUE=8'h03, WHITE=8'hFF, and the default WIDTH/HEIGHT.
REQ-040 Pixel-format conversion SHALL be sub-module cam_pixel_conv (combinational, 16-bit pixel plus mode in, 8-bit out); synchronizer, FSM and counters SHALL stay in cam_capture_ctrl.

Verification
REQ-041 MODE0, 176x144 frame of p=16'hF800 -> 25344 W_EN pulses, W_DATA=8'hE0, last W_ADDR=25343, one FRAME_DONE, FRAME_CNT=1.
REQ-042 MODE2, p=16'h0333 -> 8'hFF; p=16'h0400 -> 8'hE0; p=16'h0002 -> 8'h03; p=16'h0101 -> 8'h00.
REQ-043 Line of 180 pixels, WIDTH=176 -> 176 writes, OVERFLOW=1, next line starts at W_ADDR=176.
REQ-044 RESET asserted at pixel 50 of line 10 -> no W_EN until next VSYNC rise; next frame's first W_ADDR=0.
REQ-045 ENABLE=0 at VSYNC rise -> zero W_EN and no FRAME_DONE for that frame; ENABLE=1 next frame -> normal capture.
REQ-046 VSYNC rise and HREF fall on the same sample -> x=y=0 with no y increment; MODE change mid-frame -> takes effect next frame only.

Source files
------------

// File: rtl/cam_pkg.sv
// cam_pkg: shared definitions for the camera capture slice.
// Holds the MODE encodings, the capture FSM states, the RGB332 colour
// constants produced by the classifier, and the default frame geometry.
package cam_pkg;

  typedef enum logic [1:0] {
    MODE_RGB565   = 2'd0,
    MODE_RGB444   = 2'd1,
    MODE_CLASSIFY = 2'd2,
    MODE_RAW      = 2'd3
  } cam_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_LINE
  } cap_state_e;

  localparam logic [7:0] RED   = 8'hE0;
  localparam logic [7:0] GREEN = 8'h1C;
  localparam logic [7:0] BLUE  = 8'h03;
  localparam logic [7:0] WHITE = 8'hFF;
  localparam logic [7:0] BLACK = 8'h00;

  localparam int DEF_WIDTH  = 176;
  localparam int DEF_HEIGHT = 144;
  localparam int DEF_ADDR_W = 15;

endpackage

// File: rtl/cam_capture_ctrl_if.sv
// cam_capture_ctrl_if: camera byte bus in, frame-memory write bus out.
//   CAM_PCLK/CAM_VSYNC/CAM_HREF/CAM_DATA : raw camera signals (async to CLK)
//   W_ADDR/W_DATA/W_EN                   : one-CLK memory write strobe
// master = capture controller, slave = camera/memory side.
interface cam_capture_ctrl_if
  import cam_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              CAM_PCLK;
  logic              CAM_VSYNC;
  logic              CAM_HREF;
  logic [7:0]        CAM_DATA;
  logic [ADDR_W-1:0] W_ADDR;
  logic [7:0]        W_DATA;
  logic              W_EN;

  modport master (
    input  CAM_PCLK, CAM_VSYNC, CAM_HREF, CAM_DATA,
    output W_ADDR, W_DATA, W_EN
  );

  modport slave (
    output CAM_PCLK, CAM_VSYNC, CAM_HREF, CAM_DATA,
    input  W_ADDR, W_DATA, W_EN
  );
endinterface

// File: rtl/cam_pixel_conv.sv
// cam_pixel_conv: combinational 16-bit camera pixel -> RGB332 byte.
//   pixel : {second byte, first byte} of a camera pixel
//   mode  : output format (RGB565, RGB444, classify, raw low byte)
//   rgb   : RGB332 result
module cam_pixel_conv
  import cam_pkg::*;
#(
  parameter logic [3:0] THR_W = 4'd3,
  parameter logic [3:0] THR_R = 4'd3,
  parameter logic [3:0] THR_B = 4'd2
) (
  input  logic [15:0] pixel,
  input  cam_mode_e   mode,
  output logic [7:0]  rgb
);
  logic [3:0] r, g, b;

  always_comb begin
    r   = pixel[11:8];
    g   = pixel[7:4];
    b   = pixel[3:0];
    rgb = BLACK;
    case (mode)
      MODE_RGB565: rgb = {pixel[15:13], pixel[10:8], pixel[4:3]};
      MODE_RGB444: rgb = {pixel[11:9], pixel[7:5], pixel[3:2]};
      MODE_CLASSIFY: begin
        // Priority order: white beats red beats blue.
        if (r >= THR_W && g >= THR_W && b >= THR_W) rgb = WHITE;
        else if (r > THR_R)                         rgb = RED;
        else if (b >= THR_B)                        rgb = BLUE;
        else                                        rgb = BLACK;
      end
      MODE_RAW:    rgb = pixel[7:0];
      default:     rgb = BLACK;
    endcase
  end
endmodule

// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: captures camera frames into a pixel memory.
//   CLK, RESET  : system clock, synchronous active-high reset
//   bus         : camera inputs and memory write outputs (master side)
//   MODE        : pixel format, latched at each VSYNC rise
//   ENABLE      : capture enable, latched at each VSYNC rise
//   FRAME_DONE  : one-CLK pulse when a frame with >=1 write is closed
//   FRAME_CNT   : captured-frame counter (wraps)
//   OVERFLOW    : sticky, set when a pixel lands outside WIDTH x HEIGHT
// Camera signals are oversampled by CLK (>= 4x PCLK); all work happens on
// the CLK cycle where the synchronized PCLK is seen rising.
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int         WIDTH  = DEF_WIDTH,
  parameter int         HEIGHT = DEF_HEIGHT,
  parameter int         ADDR_W = DEF_ADDR_W,
  parameter logic [3:0] THR_W  = 4'd3,
  parameter logic [3:0] THR_R  = 4'd3,
  parameter logic [3:0] THR_B  = 4'd2
) (
  input  logic                CLK,
  input  logic                RESET,
  cam_capture_ctrl_if.master  bus,
  input  logic [1:0]          MODE,
  input  logic                ENABLE,
  output logic                FRAME_DONE,
  output logic [7:0]          FRAME_CNT,
  output logic                OVERFLOW
);
  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam logic [XW-1:0] X_MAX = XW'(WIDTH);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT);

  logic [2:0]  ctl_m, ctl_s;   // {pclk, vsync, href}
  logic [7:0]  data_m, data_s;
  logic        pclk_s, vsync_s, href_s;
  logic        pclk_d, vsync_prev;
  logic        pclk_rise, vsync_rise;

  cap_state_e  state;
  cam_mode_e   mode_q;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic        phase;
  logic [7:0]  lo_byte;
  logic        wrote_any;
  logic        pix_in_range;
  logic [7:0]  conv_rgb;

  assign {pclk_s, vsync_s, href_s} = ctl_s;
  assign pclk_rise    = pclk_s & ~pclk_d;
  // vsync_prev only advances on PCLK samples, so this compares consecutive
  // camera samples rather than consecutive CLK cycles.
  assign vsync_rise   = vsync_s & ~vsync_prev;
  assign pix_in_range = (x_cnt < X_MAX) && (y_cnt < Y_MAX);

  cam_pixel_conv #(
    .THR_W(THR_W),
    .THR_R(THR_R),
    .THR_B(THR_B)
  ) u_conv (
    .pixel({data_s, lo_byte}),
    .mode (mode_q),
    .rgb  (conv_rgb)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctl_m      <= '0;
      ctl_s      <= '0;
      data_m     <= '0;
      data_s     <= '0;
      pclk_d     <= 1'b0;
      vsync_prev <= 1'b0;
      state      <= ST_IDLE;
      mode_q     <= MODE_RGB565;
      x_cnt      <= '0;
      y_cnt      <= '0;
      phase      <= 1'b0;
      lo_byte    <= '0;
      wrote_any  <= 1'b0;
      bus.W_EN   <= 1'b0;
      bus.W_ADDR <= '0;
      bus.W_DATA <= '0;
      FRAME_DONE <= 1'b0;
      FRAME_CNT  <= '0;
      OVERFLOW   <= 1'b0;
    end else begin
      ctl_m      <= {bus.CAM_PCLK, bus.CAM_VSYNC, bus.CAM_HREF};
      ctl_s      <= ctl_m;
      data_m     <= bus.CAM_DATA;
      data_s     <= data_m;
      pclk_d     <= pclk_s;
      bus.W_EN   <= 1'b0;
      FRAME_DONE <= 1'b0;

      if (pclk_rise) begin
        vsync_prev <= vsync_s;
        // VSYNC is tested first so it wins over a simultaneous HREF fall.
        if (vsync_rise) begin
          if (wrote_any) begin
            FRAME_DONE <= 1'b1;
            FRAME_CNT  <= FRAME_CNT + 8'd1;
          end
          wrote_any <= 1'b0;
          x_cnt     <= '0;
          y_cnt     <= '0;
          phase     <= 1'b0;
          mode_q    <= cam_mode_e'(MODE);
          state     <= ENABLE ? ST_FRAME : ST_IDLE;
        end else begin
          case (state)
            ST_IDLE: ;
            ST_FRAME: begin
              // The sample that shows HREF high already carries byte 0.
              if (href_s) begin
                state   <= ST_LINE;
                lo_byte <= data_s;
                phase   <= 1'b1;
              end
            end
            ST_LINE: begin
              if (!href_s) begin
                state <= ST_FRAME;
                if (y_cnt != Y_MAX) y_cnt <= y_cnt + YW'(1);
                x_cnt <= '0;
                phase <= 1'b0;
              end else if (!phase) begin
                lo_byte <= data_s;
                phase   <= 1'b1;
              end else begin
                phase <= 1'b0;
                if (pix_in_range) begin
                  bus.W_EN   <= 1'b1;
                  bus.W_ADDR <= ADDR_W'(32'(y_cnt) * 32'(WIDTH) + 32'(x_cnt));
                  bus.W_DATA <= conv_rgb;
                  wrote_any  <= 1'b1;
                  x_cnt      <= x_cnt + XW'(1);
                end else begin
                  OVERFLOW <= 1'b1;
                end
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb_cam_capture_ctrl: directed frame sequence with random pixel content,
// checked against a frame-level reference model kept in queues.
// The DUT is built with a reduced frame size so whole frames stay short.
module tb_cam_capture_ctrl;
  import cam_pkg::*;

  localparam int W  = 20;
  localparam int H  = 6;
  localparam int AW = 15;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic       enable;
  logic       frame_done;
  logic [7:0] frame_cnt;
  logic       overflow;

  cam_capture_ctrl_if #(.ADDR_W(AW)) cam ();

  cam_capture_ctrl #(
    .WIDTH (W),
    .HEIGHT(H),
    .ADDR_W(AW)
  ) dut (
    .CLK       (clk),
    .RESET     (rst),
    .bus       (cam),
    .MODE      (mode),
    .ENABLE    (enable),
    .FRAME_DONE(frame_done),
    .FRAME_CNT (frame_cnt),
    .OVERFLOW  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t got_q[$];
  wr_t exp_q[$];
  int  n_total, n_pass, n_fail;
  int  done_cnt, exp_done;

  // Reference model state: frame-level bookkeeping only.
  bit  m_cap, m_wrote, exp_ovf;
  int  m_mode, m_x, m_y, exp_cnt;

  always @(negedge clk) begin
    if (cam.W_EN === 1'b1) got_q.push_back('{addr: cam.W_ADDR, data: cam.W_DATA});
    if (frame_done === 1'b1) done_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] got_addr(input int i);
    if (i < got_q.size()) return 32'(got_q[i].addr);
    return 'x;
  endfunction

  function automatic logic [31:0] got_data(input int i);
    if (i < got_q.size()) return 32'(got_q[i].data);
    return 'x;
  endfunction

  function automatic logic [7:0] ref_pixel(input logic [15:0] p, input int m);
    int r, g, b;
    r = int'(p[11:8]);
    g = int'(p[7:4]);
    b = int'(p[3:0]);
    case (m)
      0: return {p[15:13], p[10:8], p[4:3]};
      1: return {p[11:9], p[7:5], p[3:2]};
      2: begin
        if (r >= 3 && g >= 3 && b >= 3) return 8'hFF;
        if (r > 3)                       return 8'hE0;
        if (b >= 2)                      return 8'h03;
        return 8'h00;
      end
      default: return p[7:0];
    endcase
  endfunction

  task automatic model_vsync();
    if (m_wrote) begin
      exp_done++;
      exp_cnt = (exp_cnt + 1) % 256;
    end
    m_wrote = 0;
    m_x     = 0;
    m_y     = 0;
    m_cap   = enable;
    m_mode  = int'(mode);
  endtask

  task automatic model_pixel(input logic [15:0] p);
    if (!m_cap) return;
    if (m_x < W && m_y < H) begin
      exp_q.push_back('{addr: AW'(m_y * W + m_x), data: ref_pixel(p, m_mode)});
      m_wrote = 1;
    end else begin
      exp_ovf = 1;
    end
    m_x++;
  endtask

  task automatic model_line_end();
    m_x = 0;
    if (m_y < H) m_y++;
  endtask

  task automatic model_reset();
    m_cap   = 0;
    m_wrote = 0;
    m_x     = 0;
    m_y     = 0;
    exp_cnt = 0;
    exp_ovf = 0;
  endtask

  // One camera sample: PCLK low for 2 CLK with new values, then high for 2 CLK.
  task automatic pclk_byte(input logic [7:0] d, input logic h, input logic v);
    @(negedge clk);
    cam.CAM_PCLK  = 1'b0;
    cam.CAM_DATA  = d;
    cam.CAM_HREF  = h;
    cam.CAM_VSYNC = v;
    repeat (2) @(negedge clk);
    cam.CAM_PCLK = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_pixels(input logic [15:0] px[$]);
    foreach (px[i]) begin
      pclk_byte(px[i][7:0], 1'b1, 1'b0);
      pclk_byte(px[i][15:8], 1'b1, 1'b0);
      model_pixel(px[i]);
    end
  endtask

  task automatic end_line();
    model_line_end();
    pclk_byte(8'h00, 1'b0, 1'b0);
    pclk_byte(8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_vsync();
    model_vsync();
    pclk_byte(8'h00, 1'b0, 1'b1);
    pclk_byte(8'h00, 1'b0, 1'b1);
    pclk_byte(8'h00, 1'b0, 1'b0);
    pclk_byte(8'h00, 1'b0, 1'b0);
  endtask

  // Line whose closing HREF fall coincides with a VSYNC rise.
  task automatic send_line_vsync_end(input logic [15:0] px[$]);
    send_pixels(px);
    model_vsync();
    pclk_byte(8'h00, 1'b0, 1'b1);
    pclk_byte(8'h00, 1'b0, 1'b1);
    pclk_byte(8'h00, 1'b0, 1'b0);
    pclk_byte(8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_line(input logic [15:0] px[$]);
    send_pixels(px);
    end_line();
  endtask

  function automatic void rand_px(output logic [15:0] px[$], input int n);
    px.delete();
    for (int i = 0; i < n; i++) px.push_back(16'($urandom));
  endfunction

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), got_addr(i), 32'(exp_q[i].addr));
      check($sformatf("%s_data%0d", tag, i), got_data(i), 32'(exp_q[i].data));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_status(input string tag);
    check({tag, "_done"}, done_cnt, exp_done);
    check({tag, "_cnt"}, frame_cnt, exp_cnt);
    check({tag, "_ovf"}, overflow, exp_ovf);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    check({tag, "_wen"},   cam.W_EN, 1'b0);
    check({tag, "_waddr"}, cam.W_ADDR, '0);
    check({tag, "_wdata"}, cam.W_DATA, '0);
    check({tag, "_fdone"}, frame_done, 1'b0);
    check({tag, "_fcnt"},  frame_cnt, 8'd0);
    check({tag, "_ovf"},   overflow, 1'b0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] px[$];
    n_total = 0; n_pass = 0; n_fail = 0; done_cnt = 0; exp_done = 0;
    cam.CAM_PCLK = 1'b0; cam.CAM_VSYNC = 1'b0; cam.CAM_HREF = 1'b0; cam.CAM_DATA = '0;
    mode = 2'd0; enable = 1'b1; rst = 1'b1;
    model_reset();
    do_reset("rst0");

    // Frame A: uniform red RGB565 over the full frame.
    send_vsync();
    for (int y = 0; y < H; y++) begin
      px.delete();
      for (int x = 0; x < W; x++) px.push_back(16'hF800);
      send_line(px);
    end
    mode = 2'd2;
    send_vsync();
    check("A_nwr_const", got_q.size(), W * H);
    check("A_last_addr", got_addr(got_q.size() - 1), W * H - 1);
    check("A_data0", got_data(0), 8'hE0);
    check("A_done_const", done_cnt, 1);
    check("A_cnt_const", frame_cnt, 8'd1);
    check_status("A");
    check_writes("A");

    // Frame B: classify mode; MODE changed mid-frame must not apply.
    px = '{16'h0333, 16'h0400, 16'h0002, 16'h0101};
    for (int i = 0; i < 6; i++) px.push_back(16'($urandom));
    send_line(px);
    mode = 2'd0;
    rand_px(px, W);
    send_line(px);
    rand_px(px, 7);
    send_line(px);
    mode = 2'd3;
    send_vsync();
    check("B_cls_white", got_data(0), 8'hFF);
    check("B_cls_red",   got_data(1), 8'hE0);
    check("B_cls_blue",  got_data(2), 8'h03);
    check("B_cls_black", got_data(3), 8'h00);
    check_status("B");
    check_writes("B");

    // Frame C: raw mode, over-long line then a short line.
    rand_px(px, W + 4);
    send_line(px);
    check("C_ovf_set", overflow, 1'b1);
    rand_px(px, 5);
    send_line(px);
    enable = 1'b0;
    mode = 2'd1;
    send_vsync();
    check("C_line1_addr", got_addr(W), W);
    check_status("C");
    check_writes("C");

    // Frame D: disabled at frame start, must be ignored entirely.
    rand_px(px, W);
    send_line(px);
    rand_px(px, W);
    send_line(px);
    enable = 1'b1;
    send_vsync();
    check("D_no_wen", got_q.size(), 0);
    check_status("D");
    check_writes("D");

    // Frame E: RGB444; last HREF fall coincides with the next VSYNC rise.
    rand_px(px, W);
    send_line(px);
    mode = 2'd0;
    rand_px(px, 3);
    send_line_vsync_end(px);
    check_status("E");
    check_writes("E");

    // Frame F: must start at y=0; reset lands mid-line.
    rand_px(px, 2);
    send_line(px);
    check("F_first_addr", got_addr(0), 0);
    rand_px(px, W);
    send_line(px);
    rand_px(px, 10);
    send_pixels(px);
    repeat (8) @(negedge clk);
    check_status("F_pre");
    check_writes("F_pre");
    do_reset("rst_mid");
    rand_px(px, 5);
    send_pixels(px);
    end_line();
    rand_px(px, W);
    send_line(px);
    check("F_post_rst_wen", got_q.size(), 0);
    send_vsync();
    check_status("F_post");
    check_writes("F_post");

    // Frame G: normal capture resumes from address 0.
    rand_px(px, 3);
    send_line(px);
    check("G_first_addr", got_addr(0), 0);
    send_vsync();
    check("G_cnt_const", frame_cnt, 8'd1);
    check_status("G");
    check_writes("G");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
